// File: rtl/alu_seq_pkg.sv
// Shared execute-stage constants: EXE_* opcodes (also used by the decoder) and
// the alu_seq control state encodings.
package alu_seq_pkg;

  localparam logic [3:0] EXE_MOV = 4'd0;
  localparam logic [3:0] EXE_MVN = 4'd1;
  localparam logic [3:0] EXE_ADD = 4'd2;
  localparam logic [3:0] EXE_ADC = 4'd3;
  localparam logic [3:0] EXE_SUB = 4'd4;
  localparam logic [3:0] EXE_SBC = 4'd5;
  localparam logic [3:0] EXE_AND = 4'd6;
  localparam logic [3:0] EXE_ORR = 4'd7;
  localparam logic [3:0] EXE_EOR = 4'd8;
  localparam logic [3:0] EXE_CMP = 4'd9;
  localparam logic [3:0] EXE_TST = 4'd10;
  localparam logic [3:0] EXE_LDR = 4'd11;
  localparam logic [3:0] EXE_STR = 4'd12;
  localparam logic [3:0] EXE_MUL = 4'd13;

  typedef enum logic {
    ALU_SEQ_IDLE = 1'b0,
    ALU_SEQ_MUL  = 1'b1
  } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier retiring MUL_BPC multiplier bits per
// cycle. done pulses combinationally during the last iteration with product valid.
module alu_seq_mul #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int K     = WIDTH / MUL_BPC;
  localparam int CNT_W = $clog2(K + 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, acc_step;

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    done     = 1'b0;
    acc_step = acc_q;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (b_q[j]) acc_step = acc_step + (a_q << j);
    end
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      a_d   = a;
      b_d   = b;
      acc_d = '0;
    end else if (run_q) begin
      acc_d = acc_step;
      a_d   = a_q << MUL_BPC;
      b_d   = b_q >> MUL_BPC;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(K - 1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
    product = acc_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  // Operand/accumulator datapath carries no reset; run_q qualifies it.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result and NZCV flags.
// Define ALU_SEQ_MUL_EN to build the iterative multi-cycle MUL path.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             c_in,
  input  logic [3:0]       exe_cmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       nzcv,
  output logic             busy
);

  if (WIDTH < 8 || (MUL_BPC != 1 && MUL_BPC != 2 && MUL_BPC != 4) || (WIDTH % MUL_BPC) != 0) begin : g_bad_cfg
    $error("alu_seq: unsupported WIDTH/MUL_BPC combination");
  end

  // Returns {nzcv, result}; arithmetic is done one bit wider to expose carry/borrow.
  function automatic logic [WIDTH+3:0] alu_calc(input logic [3:0] cmd, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0] s;
    logic           cf, vf;
    s  = '0;
    cf = 1'b0;
    vf = 1'b0;
    case (cmd)
      EXE_MOV: s = {1'b0, b};
      EXE_MVN: s = {1'b0, ~b};
      EXE_ADD, EXE_ADC: begin
        s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin & (cmd == EXE_ADC)};
        cf = s[WIDTH];
        vf = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ s[WIDTH-1]);
      end
      EXE_SUB, EXE_CMP, EXE_SBC: begin
        s = {1'b0, a} - {1'b0, b};
        if (cmd == EXE_SBC) s = s + {{WIDTH{1'b0}}, cin} - (WIDTH+1)'(1);
        cf = s[WIDTH];
        vf = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ s[WIDTH-1]);
      end
      EXE_AND, EXE_TST: s = {1'b0, a & b};
      EXE_ORR:          s = {1'b0, a | b};
      EXE_EOR:          s = {1'b0, a ^ b};
      EXE_LDR, EXE_STR: begin
        s  = {1'b0, a} + {1'b0, b};
        cf = s[WIDTH];
      end
      default: s = '0;
    endcase
    return {s[WIDTH-1], (s[WIDTH-1:0] == '0), cf, vf, s[WIDTH-1:0]};
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic [WIDTH+3:0] calc;
  logic             fire, drain;

  assign calc  = alu_calc(exe_cmd, val1, val2, c_in);
  assign drain = out_valid_q && out_ready;
  assign fire  = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  alu_seq_state_e   state_q, state_d;
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_seq_mul #(.WIDTH(WIDTH), .MUL_BPC(MUL_BPC)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (val1),
    .b       (val2),
    .done    (mul_done),
    .product (mul_product)
  );

  assign in_ready = (state_q == ALU_SEQ_IDLE) && (!out_valid_q || out_ready);
  assign busy     = (state_q == ALU_SEQ_MUL);

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    alu_out_d   = drain ? '0 : alu_out_q;
    nzcv_d      = drain ? '0 : nzcv_q;
    state_d     = state_q;
    mul_start   = 1'b0;
    case (state_q)
      ALU_SEQ_IDLE: begin
        if (fire && exe_cmd == EXE_MUL) begin
          mul_start = 1'b1;
          state_d   = ALU_SEQ_MUL;
        end else if (fire) begin
          out_valid_d = 1'b1;
          alu_out_d   = calc[WIDTH-1:0];
          nzcv_d      = calc[WIDTH+3:WIDTH];
        end
      end
      ALU_SEQ_MUL: begin
        if (mul_done) begin
          out_valid_d = 1'b1;
          alu_out_d   = mul_product;
          nzcv_d      = {mul_product[WIDTH-1], (mul_product == '0), 2'b00};
          state_d     = ALU_SEQ_IDLE;
        end
      end
      default: state_d = ALU_SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ALU_SEQ_IDLE;
    else     state_q <= state_d;
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    alu_out_d   = drain ? '0 : alu_out_q;
    nzcv_d      = drain ? '0 : nzcv_q;
    if (fire) begin
      out_valid_d = 1'b1;
      alu_out_d   = calc[WIDTH-1:0];
      nzcv_d      = calc[WIDTH+3:WIDTH];
    end
  end
`endif

  // Output register stage: result and flags are architecturally visible, so they reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      nzcv_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      nzcv_q      <= nzcv_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign nzcv      = nzcv_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; exercises the MUL path when
// ALU_SEQ_MUL_EN is defined, and the single-cycle MUL fallback otherwise.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_BPC = 1;
  localparam int K       = WIDTH / MUL_BPC;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, c_in, out_valid, out_ready, busy;
  logic [WIDTH-1:0] val1, val2, alu_out;
  logic [3:0]       exe_cmd, nzcv;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(WIDTH), .MUL_BPC(MUL_BPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .val1      (val1),
    .val2      (val2),
    .c_in      (c_in),
    .exe_cmd   (exe_cmd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .nzcv      (nzcv),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input logic cin);
    exe_cmd  = cmd;
    val1     = a;
    val2     = b;
    c_in     = cin;
    in_valid = 1'b1;
  endtask

  task automatic issue(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic cin);
    drive(cmd, a, b, cin);
    #1;
    check({tag, ".in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] r, input logic [3:0] f);
    check({tag, ".out_valid"}, out_valid, 1'b1);
    check({tag, ".alu_out"}, alu_out, r);
    check({tag, ".nzcv"}, nzcv, f);
  endtask

  typedef struct {
    string       tag;
    logic [3:0]  cmd;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    val1 = '0; val2 = '0; c_in = 1'b0; exe_cmd = EXE_MOV;

    vecs.push_back('{"add_ovf", EXE_ADD, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 4'b1001});
    vecs.push_back('{"sub_eq",  EXE_SUB, 32'd5,         32'd5,         1'b0, 32'h0,         4'b0100});
    vecs.push_back('{"adc_wrap",EXE_ADC, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0,         4'b0110});
    vecs.push_back('{"sub_neg", EXE_SUB, 32'd3,         32'd5,         1'b0, 32'hFFFF_FFFE, 4'b1010});
    vecs.push_back('{"sub_ovf", EXE_SUB, 32'h8000_0000, 32'h1,         1'b0, 32'h7FFF_FFFF, 4'b0001});
    vecs.push_back('{"sbc_1",   EXE_SBC, 32'd5,         32'd3,         1'b0, 32'h1,         4'b0000});
    vecs.push_back('{"sbc_0",   EXE_SBC, 32'd0,         32'd0,         1'b0, 32'hFFFF_FFFF, 4'b1010});
    vecs.push_back('{"cmp",     EXE_CMP, 32'd5,         32'd5,         1'b0, 32'h0,         4'b0100});
    vecs.push_back('{"mvn",     EXE_MVN, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF, 4'b1000});
    vecs.push_back('{"mov",     EXE_MOV, 32'hFFFF,      32'h1234_5678, 1'b0, 32'h1234_5678, 4'b0000});
    vecs.push_back('{"tst",     EXE_TST, 32'hF0,        32'h0F,        1'b0, 32'h0,         4'b0100});
    vecs.push_back('{"orr",     EXE_ORR, 32'hF0,        32'h0F,        1'b0, 32'hFF,        4'b0000});
    vecs.push_back('{"ldr",     EXE_LDR, 32'hFFFF_FFFF, 32'h2,         1'b0, 32'h1,         4'b0010});
    vecs.push_back('{"undef",   4'd15,   32'h1,         32'h2,         1'b1, 32'h0,         4'b0100});

    step(); step();
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.alu_out", alu_out, 32'h0);
    check("rst.nzcv", nzcv, 4'h0);
    check("rst.busy", busy, 1'b0);
    rst = 1'b0;
    step();
    check("rst.in_ready", in_ready, 1'b1);

    // Back-to-back single-cycle ops with the consumer always ready.
    foreach (vecs[i]) begin
      issue(vecs[i].tag, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].cin);
      expect_res(vecs[i].tag, vecs[i].r, vecs[i].f);
    end
    step();
    check("drain.out_valid", out_valid, 1'b0);

    // Backpressure: EOR result held while an ADD waits.
    out_ready = 1'b0;
    issue("eor", EXE_EOR, 32'hA5, 32'hFF, 1'b0);
    expect_res("eor", 32'h5A, 4'b0000);
    drive(EXE_ADD, 32'd2, 32'd3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp.in_ready", in_ready, 1'b0);
      expect_res("bp.hold", 32'h5A, 4'b0000);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_rise", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    expect_res("bp.add", 32'd5, 4'b0000);
    step();
    check("bp.drain", out_valid, 1'b0);

`ifdef ALU_SEQ_MUL_EN
    begin
      int cyc, stall;
      cyc = 0; stall = 0;
      issue("mul", EXE_MUL, 32'h0001_2345, 32'h10, 1'b1);
      while (!out_valid && cyc < 200) begin
        if (busy && !in_ready) stall++;
        step();
        cyc++;
      end
      check("mul.latency", cyc, K);
      check("mul.stall_cycles", stall, K);
      check("mul.busy_after", busy, 1'b0);
      expect_res("mul", 32'h0012_3450, 4'b0000);
      step();

      issue("mul_abort", EXE_MUL, 32'hFFFF, 32'hFFFF, 1'b0);
      for (int c = 0; c < 9; c++) step();
      check("abort.busy_before", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort.out_valid", out_valid, 1'b0);
      check("abort.busy", busy, 1'b0);
      check("abort.alu_out", alu_out, 32'h0);
      check("abort.in_ready", in_ready, 1'b1);
      issue("abort.add", EXE_ADD, 32'd2, 32'd3, 1'b0);
      expect_res("abort.add", 32'd5, 4'b0000);
      step();
    end
`else
    issue("mul_off", EXE_MUL, 32'd7, 32'd9, 1'b0);
    expect_res("mul_off", 32'h0, 4'b0100);
    check("mul_off.busy", busy, 1'b0);
    step();

    out_ready = 1'b0;
    issue("rst_hold", EXE_MOV, 32'h0, 32'h55, 1'b0);
    expect_res("rst_hold", 32'h55, 4'b0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_hold.out_valid", out_valid, 1'b0);
    check("rst_hold.alu_out", alu_out, 32'h0);
    check("rst_hold.in_ready", in_ready, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
